// File: rtl/load_store_unit_if.sv
// load_store_unit_if: ready/request data-memory port between the load/store unit and memory.
interface load_store_unit_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   modport master (output req, we, addr, be, wdata, input rdata, ready);
   modport slave  (input req, we, addr, be, wdata, output rdata, ready);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store with alignment/legality checks and extended load data.
// Optional LSU_TIMEOUT_EN aborts a request after TIMEOUT_CYCLES REQ cycles without mem.ready.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        stall,
   output logic        fault,
   load_store_unit_if.master mem
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   state_t      state;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;
   logic        access, illegal;
   logic [3:0]  be;
   logic [31:0] wdata, rd_ext;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
`ifdef LSU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
`endif
   always_comb begin
      access  = MemRead | MemWrite;
      illegal = (MemRead & MemWrite)
              | (MemRead ? (funct3 == 3'b011 || funct3[2:1] == 2'b11) : (funct3[2] || funct3[1:0] == 2'b11))
              | (funct3[1:0] == 2'b01 && addr[0])
              | (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
      be      = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata   = !MemWrite ? 32'h0 :
                funct3[1:0] == 2'b00 ? {4{WriteData[7:0]}} :
                funct3[1:0] == 2'b01 ? {2{WriteData[15:0]}} : WriteData;
      byte_v  = mem.rdata[{lo_q, 3'b000} +: 8];
      half_v  = lo_q[1] ? mem.rdata[31:16] : mem.rdata[15:0];
      // funct3[2] selects the unsigned (BU/HU) variants
      rd_ext  = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_v[7]}}, byte_v} :
                f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half_v[15]}}, half_v} : mem.rdata;
      stall   = (state == IDLE && access) || state == REQ;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         ReadData  <= '0;
         fault     <= 1'b0;
         mem.req   <= 1'b0;
         mem.we    <= 1'b0;
         mem.addr  <= '0;
         mem.be    <= '0;
         mem.wdata <= '0;
         f3_q      <= '0;
         lo_q      <= '0;
`ifdef LSU_TIMEOUT_EN
         cnt       <= '0;
`endif
      end else begin
`ifdef LSU_TIMEOUT_EN
         cnt <= state == REQ ? cnt + 1'b1 : '0;
`endif
         case (state)
            IDLE: if (access) begin
               if (illegal) begin
                  fault <= 1'b1;
                  state <= DONE;
               end else begin
                  mem.req   <= 1'b1;
                  mem.we    <= MemWrite;
                  mem.addr  <= {addr[31:2], 2'b00};
                  mem.be    <= be;
                  mem.wdata <= wdata;
                  f3_q      <= funct3;
                  lo_q      <= addr[1:0];
                  state     <= REQ;
               end
            end
            REQ: if (mem.ready) begin
               if (!mem.we) ReadData <= rd_ext;
               mem.req <= 1'b0;
               state   <= DONE;
            end
`ifdef LSU_TIMEOUT_EN
            else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               mem.req <= 1'b0;
               fault   <= 1'b1;
               state   <= DONE;
            end
`endif
            default: begin
               fault <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
endmodule
